gpio_in_conditioner: RTL
========================

Name: gpio_in_conditioner

Overview:
Input-side conditioner placed directly downstream of the GPIO pad block. It consumes the raw pin levels: per bit it synchronises, debounces, detects edges and latches interrupt-pending flags. Pushbuttons and sensors feed the core through this block, and the core sees clean levels plus one interrupt line.

Parameters:
WIDTH, 8, number of pin bits conditioned.
DEB_CYCLES, 16, consecutive cycles of a changed level required before it is accepted; legal range 1..2^CNT_W-1.
CNT_W, 16, width of each per-bit debounce counter.

Ports:
clk  input  1  system clock.
RSTn  input  1  asynchronous, active-low reset.
pin_in  input  WIDTH  raw pin levels from the GPIO pad block; asynchronous to clk.
irq_en  input  WIDTH  per-bit interrupt enable mask.
irq_rise  input  WIDTH  per-bit trigger polarity: 1 = rising edge, 0 = falling edge.
irq_clr  input  WIDTH  per-bit write-1-to-clear pulse for irq_pend.
dat_out  output  WIDTH  debounced level.
edge_pulse  output  WIDTH  one-cycle pulse on each accepted level change.
irq_pend  output  WIDTH  sticky interrupt-pending flags.
irq  output  1  registered OR of (irq_pend & irq_en).

Behaviour:
- Reset (RSTn low, asynchronous): sync flops, counters, dat_out, edge_pulse, irq_pend and irq all go to 0.
- Synchroniser: 2-flop chain per bit, sync1 then sync2. Only sync2 is used downstream.
- Debounce, per bit, evaluated on each clk edge:
  - If sync2 == dat_out: counter is set to 0.
  - Else if counter == DEB_CYCLES-1: dat_out <= sync2, counter is set to 0, edge strobe fires.
  - Else: counter increments.
- Any return of sync2 to the dat_out value restarts the count. A glitch shorter than DEB_CYCLES cycles at sync2 is never accepted.
- Latency: pin_in changes before edge 1 and is held. dat_out shows the new value after edge DEB_CYCLES+2.
- edge_pulse[i] is registered. It is high for exactly the one cycle in which dat_out[i] first shows the new value.
- irq_pend[i] set condition: edge strobe fires with a new value matching the polarity (1 with irq_rise=1, 0 with irq_rise=0).
  - Becomes 1 in the same cycle as edge_pulse.
  - Set regardless of irq_en.
- irq_pend[i] clear: cleared on the edge after irq_clr[i]=1.
  - Set and clear on the same edge: set wins, pend stays 1.
  - Clear with no pending flag: no effect.
- irq: registered, asserted one cycle after any (irq_pend & irq_en) bit is 1. Deasserts one cycle after the condition drops.
- Changing irq_rise mid-count affects only the next accepted transition. Already-pending flags are not re-evaluated.
- Reset mid-operation: all state returns to 0; partial counts are discarded.
  - A pin still at 1 after reset release is debounced afresh.
  - It is accepted after edge DEB_CYCLES+2 and counts as a rising edge.
- Bits are fully independent; simultaneous events on several bits are all captured.

Optional Feature:
Macro GPIO_IN_ANY_EDGE_EN.
- Defined:
  - Adds input port irq_any (WIDTH bits).
  - When irq_any[i]=1, any accepted transition of bit i sets irq_pend[i] and irq_rise[i] is ignored.
  - When irq_any[i]=0, behaviour is as below.
- Undefined: port absent; trigger selection uses irq_rise only.

Test Plan:
All scenarios use WIDTH=8, DEB_CYCLES=4.
1. Reset: hold RSTn low for 3 cycles with pin_in=8'hFF -> all outputs 0. After release, dat_out=8'hFF after edge 6; irq_pend=8'hFF when irq_rise=8'hFF.
2. Rising accept: irq_rise[0]=1, irq_en[0]=1, pin_in[0] 0->1 held -> dat_out[0]=1 after edge 6, edge_pulse[0] high one cycle, irq_pend[0]=1 that cycle, irq=1 one cycle later.
3. Glitch reject: pin_in[1] high 3 cycles then low -> dat_out[1], edge_pulse[1] and irq_pend[1] stay 0 throughout.
4. Falling accept and clear: irq_rise[2]=0, pin_in[2] 1->0 -> irq_pend[2]=1. An irq_clr[2] pulse clears it. An irq_clr pulse coincident with a new set -> irq_pend[2] stays 1.
5. Masking: irq_en=0, accepted edge on bit 3 -> irq_pend[3]=1, irq=0. Set irq_en[3]=1 -> irq=1 one cycle later. Clear -> irq=0 one cycle after irq_pend drops.
6. Reset mid-count: pin_in[4] 0->1, RSTn low at edge 4 for 1 cycle -> dat_out[4]=0 during reset. After release, acceptance at edge 6 post-release with a rising-edge pend.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: 2-flop sync, per-bit debounce, edge strobe, sticky irq.
// Optional GPIO_IN_ANY_EDGE_EN adds irq_any to trigger on either edge per bit.
module gpio_in_conditioner #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] irq_rise,
  input  logic [WIDTH-1:0] irq_clr,
`ifdef GPIO_IN_ANY_EDGE_EN
  input  logic [WIDTH-1:0] irq_any,
`endif
  output logic [WIDTH-1:0] dat_out,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] irq_pend,
  output logic             irq
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]            accept;
  logic [WIDTH-1:0]            trig;
  logic [WIDTH-1:0]            pend_set;
  logic [WIDTH-1:0]            pend_nxt;
  logic                        irq_nxt;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive mismatching samples.
  always_comb begin
    cnt_nxt = cnt;
    accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == dat_out[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == DEB_LAST) begin
        cnt_nxt[i] = '0;
        accept[i]  = 1'b1;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end
    end
  end

  // The accepted value is sync2, so polarity match is sync2 == irq_rise.
`ifdef GPIO_IN_ANY_EDGE_EN
  assign trig = irq_any | ~(sync2 ^ irq_rise);
`else
  assign trig = ~(sync2 ^ irq_rise);
`endif

  assign pend_set = accept & trig;
  assign pend_nxt = (irq_pend & ~irq_clr) | pend_set;
  assign irq_nxt  = |(irq_pend & irq_en);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt        <= '0;
      dat_out    <= '0;
      edge_pulse <= '0;
      irq_pend   <= '0;
      irq        <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      dat_out    <= dat_out ^ accept;
      edge_pulse <= accept;
      irq_pend   <= pend_nxt;
      irq        <= irq_nxt;
    end
  end

endmodule
